alt_cal_chan_sequencer: RTL and testbench
=========================================

Name: alt_cal_chan_sequencer

Overview:
Sequences offset calibration across all transceiver channels of a quad.
- Drives a single calibration engine (start/busy interface) one channel at a time.
- Presents the channel address for each run and supervises every run with a timeout.
- Reports per-channel pass/timeout status to the reset/reconfig controller that owns bring-up.

Parameters:
number_of_channels, 4, channels sequenced; index range 0..number_of_channels-1
channel_address_width, 2, width of cal_chan_addr; must satisfy 2**channel_address_width >= number_of_channels
start_cycles, 2, cycles cal_start is held high per run; legal range 1..15
timeout_width, 11, width of supervision timer
timeout_cycles, 11'd1024, cycles allowed per wait phase before declaring timeout; must be >= 2

Ports:
clock  in  1  sole clock; all logic rising-edge
reset  in  1  synchronous, active-high; sampled on rising edge of clock
cal_req  in  1  level request to run a full sequence; sampled only in IDLE
cal_abort  in  1  stop sequence; honoured in any non-IDLE state
chan_mask  in  number_of_channels  per-channel enable; latched at sequence start
cal_busy  in  1  busy from calibration engine
cal_start  out  1  start to calibration engine
cal_chan_addr  out  channel_address_width  channel currently being calibrated
seq_busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse on normal completion
chan_pass  out  number_of_channels  bit set when that channel's run completed
chan_timeout  out  number_of_channels  bit set when that channel's run timed out

Behaviour:
- Reset: state IDLE; all outputs 0; chan_idx, timer, start counter and mask_q all 0.
- All outputs are registered. Status vectors hold their value until the next sequence start.
- IDLE:
  - cal_req=1: mask_q<=chan_mask, chan_pass<=0, chan_timeout<=0, chan_idx<=0, then go to SELECT.
  - cal_abort is ignored in IDLE.
- SELECT:
  - cal_chan_addr<=chan_idx.
  - mask_q[chan_idx]=0: go to NEXT; that channel's pass and timeout bits stay 0.
  - Otherwise load start counter with start_cycles and go to START.
- START:
  - cal_start=1 for exactly start_cycles cycles.
  - Then cal_start<=0, timer<=0, go to WAIT_RISE.
- WAIT_RISE:
  - cal_busy=1: timer<=0, go to WAIT_FALL.
  - Else timer==timeout_cycles-1: chan_timeout[chan_idx]<=1, go to NEXT.
  - Else timer++.
- WAIT_FALL:
  - cal_busy=0: chan_pass[chan_idx]<=1, go to NEXT.
  - Else timer==timeout_cycles-1: chan_timeout[chan_idx]<=1, go to NEXT.
  - Else timer++.
- In both wait states, if the busy condition and the timeout occur in the same cycle, the busy condition wins (the run counts as success/progress).
- NEXT:
  - chan_idx==number_of_channels-1: go to DONE.
  - Else chan_idx++ and go to SELECT. No wrap; chan_idx never exceeds number_of_channels-1.
- DONE: seq_done=1 for one cycle, then go to IDLE.
- cal_abort=1 in any non-IDLE state:
  - Go to IDLE on the next edge; cal_start<=0.
  - No seq_done pulse.
  - Status bits already set are kept; the bit for the aborted channel is not set.
  - cal_abort has priority over every transition in the same cycle.
- cal_req held high continuously: a new sequence starts on the cycle after DONE returns to IDLE.
- cal_req during a sequence is ignored.
- chan_mask changes mid-sequence have no effect, because mask_q is used throughout.
- cal_chan_addr is stable from SELECT through NEXT of each channel. It is 0 after reset and holds its last value in IDLE.
- Latency for an all-masked sequence: SELECT/NEXT per channel, then DONE. That is 2*number_of_channels+1 cycles after leaving IDLE until seq_done.
- reset mid-sequence returns every register to its reset value on the next edge, regardless of state.

Test Plan:
- Mask 4'b1111; engine model asserts busy 1 cycle after start falls and holds it for 511 cycles -> cal_chan_addr steps 0,1,2,3; cal_start 2 cycles per run; chan_pass=4'b1111; chan_timeout=0; single seq_done pulse.
- Mask 4'b0101 -> cal_start issued only while cal_chan_addr=0 and 2; chan_pass=4'b0101; masked channels produce no cal_start.
- Engine never raises busy on channel 1 -> channel 1 exits WAIT_RISE exactly 1024 cycles after entry; chan_timeout=4'b0010; chan_pass=4'b1101; sequence completes.
- Busy stuck high on channel 2, and busy falls on the same cycle the timer hits 1023 on channel 3 -> chan_timeout[2]=1; chan_pass[3]=1, because busy wins.
- cal_abort pulsed during WAIT_FALL of channel 1 -> IDLE next cycle; cal_start=0; no seq_done; chan_pass=4'b0001.
- reset asserted during START of channel 2 -> next cycle all outputs 0 and state IDLE; cal_req held high -> fresh sequence begins at channel 0.

Source files
------------

// File: rtl/alt_cal_chan_sequencer.sv
// rtl/alt_cal_chan_sequencer.sv - per-channel offset calibration sequencer for a transceiver quad
// Runs one calibration engine across all enabled channels, supervising each run with a timeout.
module alt_cal_chan_sequencer #(
  parameter int unsigned number_of_channels    = 4,
  parameter int unsigned channel_address_width = 2,
  parameter int unsigned start_cycles          = 2,
  parameter int unsigned timeout_width         = 11,
  parameter logic [timeout_width-1:0] timeout_cycles = 11'd1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cal_req,
  input  logic                             cal_abort,
  input  logic [number_of_channels-1:0]    chan_mask,
  input  logic                             cal_busy,
  output logic                             cal_start,
  output logic [channel_address_width-1:0] cal_chan_addr,
  output logic                             seq_busy,
  output logic                             seq_done,
  output logic [number_of_channels-1:0]    chan_pass,
  output logic [number_of_channels-1:0]    chan_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [channel_address_width-1:0] last_idx =
    channel_address_width'(number_of_channels - 1);
  localparam logic [3:0] start_load = 4'(start_cycles);
  localparam logic [timeout_width-1:0] timer_last = timeout_cycles - 1'b1;

  state_t                           state_q, state_d;
  logic [number_of_channels-1:0]    mask_q, mask_d;
  logic [channel_address_width-1:0] chan_idx_q, chan_idx_d;
  logic [timeout_width-1:0]         timer_q, timer_d;
  logic [3:0]                       start_cnt_q, start_cnt_d;
  logic                             cal_start_q, cal_start_d;
  logic [channel_address_width-1:0] addr_q, addr_d;
  logic                             seq_busy_q, seq_busy_d;
  logic                             seq_done_q, seq_done_d;
  logic [number_of_channels-1:0]    pass_q, pass_d;
  logic [number_of_channels-1:0]    timeout_q, timeout_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      chan_idx_q  <= '0;
      timer_q     <= '0;
      start_cnt_q <= '0;
      cal_start_q <= 1'b0;
      addr_q      <= '0;
      seq_busy_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      pass_q      <= '0;
      timeout_q   <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      chan_idx_q  <= chan_idx_d;
      timer_q     <= timer_d;
      start_cnt_q <= start_cnt_d;
      cal_start_q <= cal_start_d;
      addr_q      <= addr_d;
      seq_busy_q  <= seq_busy_d;
      seq_done_q  <= seq_done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    chan_idx_d  = chan_idx_q;
    timer_d     = timer_q;
    start_cnt_d = start_cnt_q;
    cal_start_d = cal_start_q;
    addr_d      = addr_q;
    seq_done_d  = 1'b0;
    pass_d      = pass_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cal_req) begin
          mask_d     = chan_mask;
          pass_d     = '0;
          timeout_d  = '0;
          chan_idx_d = '0;
          state_d    = S_SELECT;
        end
      end
      S_SELECT: begin
        addr_d = chan_idx_q;
        if (!mask_q[chan_idx_q]) begin
          state_d = S_NEXT;
        end else begin
          start_cnt_d = start_load;
          cal_start_d = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        // cal_start was raised on entry, so it stays up for start_load cycles.
        if (start_cnt_q <= 4'd1) begin
          cal_start_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT_RISE;
        end else begin
          start_cnt_d = start_cnt_q - 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (cal_busy) begin
          timer_d = '0;
          state_d = S_WAIT_FALL;
        end else if (timer_q == timer_last) begin
          timeout_d[chan_idx_q] = 1'b1;
          state_d               = S_NEXT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_FALL: begin
        if (!cal_busy) begin
          pass_d[chan_idx_q] = 1'b1;
          state_d            = S_NEXT;
        end else if (timer_q == timer_last) begin
          timeout_d[chan_idx_q] = 1'b1;
          state_d               = S_NEXT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (chan_idx_q == last_idx) begin
          seq_done_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          chan_idx_d = chan_idx_q + 1'b1;
          state_d    = S_SELECT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the state above decided, keeping earlier status bits.
    if (cal_abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      cal_start_d = 1'b0;
      seq_done_d  = 1'b0;
      addr_d      = addr_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
    end

    seq_busy_d = (state_d != S_IDLE);
  end

  assign cal_start     = cal_start_q;
  assign cal_chan_addr = addr_q;
  assign seq_busy      = seq_busy_q;
  assign seq_done      = seq_done_q;
  assign chan_pass     = pass_q;
  assign chan_timeout  = timeout_q;

endmodule

// File: tb/tb_alt_cal_chan_sequencer.sv
// tb/tb_alt_cal_chan_sequencer.sv - self-checking bench for alt_cal_chan_sequencer
// Engine model reacts to cal_start; a rule-level model predicts per-channel status.
module tb_alt_cal_chan_sequencer;

  localparam int N  = 4;
  localparam int TO = 1024;
  localparam int SC = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       cal_req;
  logic       cal_abort;
  logic [3:0] chan_mask;
  logic       cal_busy;
  logic       cal_start;
  logic [1:0] cal_chan_addr;
  logic       seq_busy;
  logic       seq_done;
  logic [3:0] chan_pass;
  logic [3:0] chan_timeout;

  alt_cal_chan_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .cal_req      (cal_req),
    .cal_abort    (cal_abort),
    .chan_mask    (chan_mask),
    .cal_busy     (cal_busy),
    .cal_start    (cal_start),
    .cal_chan_addr(cal_chan_addr),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .chan_pass    (chan_pass),
    .chan_timeout (chan_timeout)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Per-channel engine behaviour: busy rises r cycles after cal_start falls, stays d cycles.
  int r_tab[N];
  int d_tab[N];

  int   starts[N];
  int   rise_cyc[N];
  int   fall_cyc[N];
  int   bad_run;
  int   done_cnt;
  int   cyc = 0;
  int   run_len = 0;
  logic mon_prev = 1'b0;
  logic [1:0] mon_addr = 2'd0;

  int   eng_t = 0;
  int   eng_ch = 0;
  logic eng_active = 1'b0;
  logic eng_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    for (int c = 0; c < N; c++) starts[c] = 0;
    bad_run  = 0;
    done_cnt = 0;
  endtask

  // Expected status from the timing rules: busy must be seen within TO cycles of waiting
  // for the rise (timer 0..TO-1), and must drop no later than timer TO-1 while waiting to fall.
  function automatic void model(input logic [3:0] m, output logic [3:0] p, output logic [3:0] t);
    p = '0;
    t = '0;
    for (int c = 0; c < N; c++) begin
      if (m[c]) begin
        if (r_tab[c] <= TO - 1 && d_tab[c] <= TO) p[c] = 1'b1;
        else t[c] = 1'b1;
      end
    end
  endfunction

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (seq_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic start_seq(input logic [3:0] m);
    logic seen;
    seen = 1'b0;
    @(negedge clock);
    clear_mon();
    chan_mask = m;
    cal_req   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (seq_busy) begin
        seen = 1'b1;
        break;
      end
    end
    cal_req   = 1'b0;
    chan_mask = 4'($urandom);
    check("seq_start", 32'(seen), 32'd1);
  endtask

  task automatic run_seq(input logic [3:0] m, input string tag);
    logic [3:0] ep, et;
    start_seq(m);
    wait_done(tag, 12000);
    @(negedge clock);
    @(negedge clock);
    model(m, ep, et);
    check({tag, "_pass"}, 32'(chan_pass), 32'(ep));
    check({tag, "_timeout"}, 32'(chan_timeout), 32'(et));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_start_runs"}, 32'(bad_run), 32'd0);
    check({tag, "_idle"}, 32'(seq_busy), 32'd0);
    for (int c = 0; c < N; c++)
      check($sformatf("%s_starts_ch%0d", tag, c), 32'(starts[c]), 32'(m[c]));
  endtask

  task automatic set_tab(input int r, input int d);
    for (int c = 0; c < N; c++) begin
      r_tab[c] = r;
      d_tab[c] = d;
    end
  endtask

  initial begin
    cal_busy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (eng_prev && !cal_start && seq_busy) begin
        eng_active = 1'b1;
        eng_t      = 0;
        eng_ch     = int'(cal_chan_addr);
      end else if (eng_active) begin
        eng_t++;
      end
      if (cal_start || !seq_busy || reset) eng_active = 1'b0;
      cal_busy = eng_active && (eng_t >= r_tab[eng_ch]) && (eng_t < r_tab[eng_ch] + d_tab[eng_ch]);
      eng_prev = cal_start;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (cal_start) begin
        if (!mon_prev) begin
          run_len            = 0;
          rise_cyc[cal_chan_addr] = cyc;
          starts[cal_chan_addr]++;
          mon_addr           = cal_chan_addr;
        end else if (cal_chan_addr != mon_addr) begin
          bad_run++;
        end
        run_len++;
      end else if (mon_prev) begin
        fall_cyc[mon_addr] = cyc;
        if (run_len != SC) bad_run++;
      end
      if (seq_done) done_cnt++;
      mon_prev = cal_start;
    end
  end

  initial begin
    int         lat;
    logic       seen;
    logic [3:0] m;

    reset     = 1'b1;
    cal_req   = 1'b0;
    cal_abort = 1'b0;
    chan_mask = 4'd0;
    set_tab(1, 1);
    clear_mon();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_cal_start", 32'(cal_start), 32'd0);
    check("rst_addr", 32'(cal_chan_addr), 32'd0);
    check("rst_seq_busy", 32'(seq_busy), 32'd0);
    check("rst_seq_done", 32'(seq_done), 32'd0);
    check("rst_pass", 32'(chan_pass), 32'd0);
    check("rst_timeout", 32'(chan_timeout), 32'd0);

    // All channels masked: latency, then back-to-back restart with cal_req held.
    clear_mon();
    chan_mask = 4'd0;
    cal_req   = 1'b1;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (seq_done) begin
        lat = i;
        break;
      end
    end
    check("masked_latency", 32'(lat), 32'(2 * N + 1));
    @(negedge clock);
    check("held_req_idle", 32'(seq_busy), 32'd0);
    @(negedge clock);
    check("held_req_restart", 32'(seq_busy), 32'd1);
    cal_req = 1'b0;
    wait_done("masked2", 50);
    @(negedge clock);
    @(negedge clock);
    check("masked_done_cnt", 32'(done_cnt), 32'd2);
    check("masked_pass", 32'(chan_pass), 32'd0);
    check("masked_starts_ch0", 32'(starts[0]), 32'd0);

    // All enabled, busy one cycle after start falls, held 511 cycles.
    set_tab(1, 511);
    run_seq(4'b1111, "all");
    check("all_gap_pass", 32'(rise_cyc[1] - fall_cyc[0]), 32'(r_tab[0] + d_tab[0] + 3));

    set_tab(1, 7);
    run_seq(4'b0101, "m0101");

    // Channel 1 never raises busy.
    set_tab(1, 9);
    r_tab[1] = 5000;
    run_seq(4'b1111, "norise");
    check("norise_gap", 32'(rise_cyc[2] - fall_cyc[1]), 32'(TO + 2));

    // Channel 2 stuck busy; channel 3 drops busy exactly as the timer expires.
    set_tab(1, 5);
    d_tab[2] = 5000;
    d_tab[3] = TO;
    run_seq(4'b1111, "stuck");

    // Abort during WAIT_FALL of channel 1.
    set_tab(1, 511);
    start_seq(4'b1111);
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (cal_chan_addr == 2'd1 && cal_busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_reach", 32'(seen), 32'd1);
    repeat (5) @(negedge clock);
    cal_abort = 1'b1;
    @(negedge clock);
    cal_abort = 1'b0;
    check("abort_idle", 32'(seq_busy), 32'd0);
    check("abort_cal_start", 32'(cal_start), 32'd0);
    repeat (20) @(negedge clock);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_pass", 32'(chan_pass), 32'd1);
    check("abort_timeout", 32'(chan_timeout), 32'd0);

    // Reset during START of channel 2 with cal_req held high.
    set_tab(1, 3);
    @(negedge clock);
    clear_mon();
    chan_mask = 4'b1111;
    cal_req   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (cal_start && cal_chan_addr == 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_reach", 32'(seen), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_cal_start", 32'(cal_start), 32'd0);
    check("rst_mid_addr", 32'(cal_chan_addr), 32'd0);
    check("rst_mid_seq_busy", 32'(seq_busy), 32'd0);
    check("rst_mid_seq_done", 32'(seq_done), 32'd0);
    check("rst_mid_pass", 32'(chan_pass), 32'd0);
    check("rst_mid_timeout", 32'(chan_timeout), 32'd0);
    @(negedge clock);
    clear_mon();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (cal_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_restart_seen", 32'(seen), 32'd1);
    check("rst_restart_addr", 32'(cal_chan_addr), 32'd0);
    cal_req = 1'b0;
    wait_done("rst_restart", 3000);
    @(negedge clock);
    check("rst_restart_pass", 32'(chan_pass), 32'hf);

    // Randomised sequences, including runs at and just past the timeout boundary.
    for (int k = 0; k < 6; k++) begin
      m = 4'($urandom_range(0, 15));
      for (int c = 0; c < N; c++) begin
        r_tab[c] = ($urandom_range(0, 9) == 0) ? 1022 + int'($urandom_range(0, 2))
                                               : int'($urandom_range(1, 20));
        d_tab[c] = ($urandom_range(0, 9) == 0) ? 1023 + int'($urandom_range(0, 2))
                                               : int'($urandom_range(1, 30));
      end
      run_seq(m, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
